// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO and exposes a busy window for the hazard unit.
// Optional MD_UNIT_EARLY_BUSY_EN: busy also asserts combinationally in the cycle a mult/div starts.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  // state  | meaning
  // S_IDLE | ready; start is accepted, mthi/mtlo write immediately
  // S_BUSY | mult/div in flight; counter runs down to 0, then HI/LO commit
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi, pend_lo;

  logic [63:0] prod_s, prod_u;
  logic [31:0] res_hi, res_lo;

  assign prod_u = {32'd0, A} * {32'd0, B};
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

  // Divide-by-zero and the signed overflow case get fixed results instead of relying on '/'.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (B == 32'd0) begin
          res_hi = A;
          res_lo = 32'hFFFF_FFFF;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_lo = $signed(A) / $signed(B);
          res_hi = $signed(A) % $signed(B);
        end
      end
      OP_DIVU: begin
        if (B == 32'd0) begin
          res_hi = A;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_lo = A / B;
          res_hi = A % B;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                cnt     <= op[1] ? DIV_LOAD : MULT_LOAD;
                busy_q  <= 1'b1;
                state   <= S_BUSY;
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          if (cnt == 8'd0) begin
            hi_q   <= pend_hi;
            lo_q   <= pend_lo;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MD_UNIT_EARLY_BUSY_EN
  assign busy = busy_q | (start & ~op[2]);
`else
  assign busy = busy_q;
`endif

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a vector table of MD ops plus hand sequences for
// back-to-back issue, start-while-busy and reset in the middle of an operation.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MD_UNIT_EARLY_BUSY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int cycles_of(input logic [2:0] o);
    if (o <= 3'd1) return MC;
    if (o <= 3'd3) return DC;
    return 0;
  endfunction

  // Issues one op on the next edge and follows it to completion.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    n = cycles_of(o);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    #1 check({tag, " start-cycle busy"}, {31'd0, busy}, {31'd0, EARLY && n > 0});
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s busy cyc%0d", tag, i), {31'd0, busy}, 32'd1);
      check($sformatf("%s HI hold cyc%0d", tag, i), hi, m_hi);
      check($sformatf("%s LO hold cyc%0d", tag, i), lo, m_lo);
      @(posedge clk); #1;
    end
    check({tag, " busy done"}, {31'd0, busy}, 32'd0);
    check({tag, " HI"}, hi, ehi);
    check({tag, " LO"}, lo, elo);
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    int hcnt;
    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5]  = '{3'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[6]  = '{3'd4, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
    vecs[7]  = '{3'd5, 32'h9ABC_DEF0, 32'd0,         32'h1234_5678, 32'h9ABC_DEF0};
    vecs[8]  = '{3'd6, 32'h0000_0001, 32'd1,         32'h1234_5678, 32'h9ABC_DEF0};
    vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999};
    vecs[10] = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[11] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

    #2;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset HI", hi, 32'd0);
    check("reset LO", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle busy", {31'd0, busy}, 32'd0);
    check("idle HI", hi, 32'd0);
    check("idle LO", lo, 32'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // back-to-back: div issued on the first edge that sees busy low after the mult
    run_op("b2b mult", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12);
    run_op("b2b div", 3'd2, 32'd100, 32'd7, 32'd2, 32'd14);

    // start with op=mult while a div is in flight must be ignored
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd20; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    hcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      hcnt++;
      if (k == 2) begin
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("ignore busy length", hcnt, DC);
    check("ignore HI", hi, 32'd2);
    check("ignore LO", lo, 32'd6);
    m_hi = 32'd2; m_lo = 32'd6;
    repeat (2) @(posedge clk);
    #1 check("ignore no late start", {31'd0, busy}, 32'd0);

    // async reset while busy with the counter at 3
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    @(posedge clk); #2;
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst HI", hi, 32'd0);
    check("async rst LO", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (MC + 2) @(posedge clk);
    #1;
    check("post-rst busy", {31'd0, busy}, 32'd0);
    check("post-rst HI", hi, 32'd0);
    check("post-rst LO", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage, alongside the ALU.
- Consumes the forwarded V1/V2 operands that regE produces and owns the architectural HI/LO registers.
- Multi-cycle busy window lets the hazard unit stall MD instructions and mfhi/mflo in D (enD low, FlushE high).
- HI/LO outputs feed the E-stage result mux ahead of regM.

Parameters:
- MULT_CYCLES, 5, cycles busy is high after a mult/multu start (range 1-255).
- DIV_CYCLES, 10, cycles busy is high after a div/divu start (range 1-255).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  E-stage instruction is an MD op; sampled on the clk edge
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 = no-op
- A  in  32  rs operand (V1 after forwarding)
- B  in  32  rt operand (V2 after forwarding)
- busy  out  1  multi-cycle operation in progress
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Reset: rst_n low asynchronously clears the following.
  - HI=0, LO=0, busy=0, counter=0, pending results=0.
  - Reset mid-operation discards the pending result; HI/LO stay 0.
- Start acceptance: start is honoured only on an edge where busy=0.
  - start while busy=1 is ignored. The hazard unit guarantees this never happens; the bench still checks the ignore.
- mult/multu/div/divu accepted at edge T:
  - Operands are captured and the result is computed into pending registers at T.
  - busy rises after T and stays high for exactly N cycles (N=MULT_CYCLES or DIV_CYCLES).
  - At edge T+N: HI/LO take the pending values, busy falls, counter=0.
  - HI/LO keep their old values throughout the busy window.
- Internal state: IDLE / BUSY, implemented as an 8-bit down-counter.
  - IDLE -> BUSY on an accepted multi-cycle start; the counter loads N-1.
  - BUSY decrements each edge; BUSY -> IDLE on the edge where the counter is 0.
- mthi/mtlo: single-cycle.
  - HI<=A (mthi) or LO<=A (mtlo) at the accepting edge; busy stays 0.
  - The other register is unchanged.
- Arithmetic rules:
  - mult: signed 32x32->64; multu: unsigned. {HI,LO}=product.
  - div: signed; LO=quotient truncated toward zero; HI=remainder, sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - Divide by zero (B=0), div and divu: LO=32'hFFFFFFFF, HI=A. Deterministic, no exception.
  - div overflow 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- Back-to-back operations:
  - A new start is accepted on the edge after busy falls, i.e. the first edge seeing busy=0.
  - No operation overlaps another.
- No flush input: an MD op reaching E commits. Cancellation is the upstream FlushE's job.

Optional Feature:
- Macro: MD_UNIT_EARLY_BUSY_EN.
- Defined: busy output = internal busy | (start & (op<=3)).
  - busy is high combinationally in the start cycle itself.
  - The hazard unit can then stall a following mfhi/mflo without a separate decode.
  - Internal timing is unchanged.
- Undefined: busy is the registered internal flag only; it first goes high the cycle after start.

Test Plan:
- Reset then idle -> HI=0, LO=0, busy=0. Assert rst_n low while busy (counter=3) -> busy=0 and HI/LO=0 immediately, before any clock edge.
- mult A=32'hFFFFFFFE (-2), B=3 -> busy high 5 cycles, HI/LO unchanged during the window; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
- multu A=32'hFFFFFFFF, B=2 -> after 5 cycles HI=1, LO=32'hFFFFFFFE.
- div A=-7 (32'hFFFFFFF9), B=2 -> busy 10 cycles; LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). divu A=7, B=0 -> LO=32'hFFFFFFFF, HI=7.
- mthi A=32'h12345678, then the next cycle mtlo A=32'h9ABCDEF0 -> HI/LO updated one edge each, busy never high. start with op=mult pulsed during a div busy window -> ignored, result equals the div only.
- Back-to-back: mult accepted, new div start on the first edge with busy=0 -> busy low for exactly that one cycle, then high 10 cycles. Repeat with MD_UNIT_EARLY_BUSY_EN defined -> busy also high in each start cycle.
